// File: rtl/pisca_multi_if.sv
// Barrier/LED bundle for pisca_multi: barrier, mode and clear inputs, LED and busy outputs.
interface pisca_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] barreira_i;
  logic [CHANNELS-1:0] mode_i;
  logic [CHANNELS-1:0] clr_i;
  logic [CHANNELS-1:0] led_o;
  logic [CHANNELS-1:0] busy_o;

  modport master (
    output barreira_i, mode_i, clr_i,
    input  led_o, busy_o
  );

  modport slave (
    input  barreira_i, mode_i, clr_i,
    output led_o, busy_o
  );
endinterface

// File: rtl/pisca_multi.sv
// Multi-channel LED blinker. A rising edge on a barrier input starts a counted burst
// or continuous blinking on that channel; each ON and OFF phase lasts HALF_PERIOD cycles.
//
//   state  | meaning
//   IDLE   | LED off, waiting for a barrier rising edge
//   ON     | LED lit, phase counter running
//   OFF    | LED dark, phase counter running; timeout decides ON or IDLE
module pisca_multi #(
  parameter int CHANNELS    = 4,
  parameter int HALF_PERIOD = 25_000_000,
  parameter int BLINKS      = 3
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  pisca_multi_if.slave   bus
);
  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int BW = $clog2(BLINKS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  logic [CHANNELS-1:0] led_vec;
  logic [CHANNELS-1:0] busy_vec;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BW-1:0]   left_q, left_d;
    logic            prev_q;
    logic            led_q, busy_q;
    logic            trig;
    logic            tmo;

    assign trig = bus.barreira_i[g] & ~prev_q;
    assign tmo  = (cnt_q == CW'(HALF_PERIOD - 1));

    // Next-state decode: clear beats trigger, trigger beats phase timeout.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      left_d  = left_q;
      if (bus.clr_i[g]) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        left_d  = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (trig) begin
              state_d = S_ON;
              cnt_d   = '0;
              left_d  = BW'(BLINKS);
            end
          end
          S_ON: begin
            if (trig) left_d = BW'(BLINKS);
            if (tmo) begin
              state_d = S_OFF;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          S_OFF: begin
            if (trig) left_d = BW'(BLINKS);
            if (tmo) begin
              cnt_d = '0;
              if (trig || bus.mode_i[g]) begin
                state_d = S_ON;
              end else if (left_q == BW'(1)) begin
                state_d = S_IDLE;
                left_d  = '0;
              end else begin
                state_d = S_ON;
                left_d  = left_q - BW'(1);
              end
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            left_d  = '0;
          end
        endcase
      end
    end

    // State and output registers; prev tracks the barrier even in reset so a
    // barrier already high at release is not seen as an edge.
    always_ff @(posedge clk_i) begin
      prev_q <= bus.barreira_i[g];
      if (!rst_n_i) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        left_q  <= '0;
        led_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        left_q  <= left_d;
        led_q   <= (state_d == S_ON);
        busy_q  <= (state_d != S_IDLE);
      end
    end

    assign led_vec[g]  = led_q;
    assign busy_vec[g] = busy_q;
  end

  assign bus.led_o  = led_vec;
  assign bus.busy_o = busy_vec;
endmodule

// File: doc/pisca_multi.md
# pisca_multi

Multi-channel, parametrised LED blinker for barrier (Barreira) sensors. Each channel watches one barrier input. A rising edge starts either a counted burst of blinks or continuous blinking, and the blink phase length is set by a parameter. Channels run independently on a single clock. The block sits between the debounced barrier inputs and the board LEDs, and it replaces the single-channel level-follow behaviour used so far.

## Interface
Parameters:
- CHANNELS, 4: number of independent barrier/LED channels (≥1).
- HALF_PERIOD, 25_000_000: clock cycles per ON phase and per OFF phase (≥1).
- BLINKS, 3: ON phases per counted burst (≥1).

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  reset. Synchronous and active-low.
- BARREIRA  in  CHANNELS  barrier inputs, synchronous to CLK; a 0→1 transition triggers that channel.
- MODE  in  CHANNELS  per channel: 0 = counted burst of BLINKS; 1 = continuous until cleared.
- CLR  in  CHANNELS  per channel: synchronous abort to idle.
- LED  out  CHANNELS  registered LED drive, 1 = lit.
- BUSY  out  CHANNELS  registered; 1 while the channel is not idle.

## Operation
- Each channel has the following registers:
  - a 2-bit FSM: IDLE, ON, OFF;
  - a phase counter of width $clog2(HALF_PERIOD) (minimum 1 bit);
  - blinks_left, of width $clog2(BLINKS+1): ON phases remaining, including the current one;
  - prev, the previous-cycle BARREIRA bit.
- Trigger: trig = BARREIRA[i] & ~prev[i]. prev loads BARREIRA every cycle, including during reset.
- LED = 1 only in ON. BUSY = 1 in ON or OFF. Both are registered and follow the FSM state directly.
- Priority per channel, highest first: RST_N low, then CLR, then trig, then phase timeout.
- In IDLE:
  - trig: go to ON, counter = 0, blinks_left = BLINKS.
  - otherwise stay in IDLE.
- In ON:
  - trig: blinks_left = BLINKS; phase and counter are not disturbed.
  - counter == HALF_PERIOD-1: go to OFF, counter = 0.
  - otherwise counter increments.
- In OFF:
  - trig: blinks_left = BLINKS. If this cycle is also the timeout, go to ON with counter = 0.
  - Timeout with MODE[i] = 1: go to ON and leave blinks_left unchanged.
  - Timeout with MODE[i] = 0 and blinks_left == 1: go to IDLE.
  - Timeout with MODE[i] = 0 and blinks_left > 1: decrement blinks_left, go to ON.
  - otherwise counter increments.
- MODE is sampled only at OFF timeout, so a change mid-phase takes effect at the end of the current OFF phase.
- CLR[i] = 1: go to IDLE and clear counter and blinks_left. A trig in the same cycle is discarded.
- Reset (RST_N low at a clock edge):
  - all FSMs go to IDLE; LED = 0, BUSY = 0; counters and blinks_left = 0;
  - prev = BARREIRA, so a barrier already high at reset release does not trigger.
- Reset applied mid-burst aborts the burst at that edge, with no further blinks.
- Channels share no state. Simultaneous triggers on any set of channels are all accepted.

## Timing
- Trigger latency: if BARREIRA[i] is first sampled high at edge k, LED[i] and BUSY[i] read 1 after edge k.
- ON and OFF phases each last exactly HALF_PERIOD cycles.
- Counted burst: BUSY is high for 2·BLINKS·HALF_PERIOD cycles, then LED = BUSY = 0.
- HALF_PERIOD = 1: LED toggles every cycle.
- CLR latency: LED = BUSY = 0 after the edge where CLR is sampled high.
- A pulse of one cycle is sufficient for trigger. A level held high does not retrigger; a new 0→1 edge is required.
- No combinational path from inputs to outputs.

## Test plan
Bench parameters: CHANNELS = 4, HALF_PERIOD = 4, BLINKS = 2.

1. Reset: hold RST_N = 0 for 3 cycles with BARREIRA = 4'hF, then release and keep BARREIRA high. Required: LED = 0 and BUSY = 0 throughout, and no blink ever starts.
2. Counted burst: MODE = 0, pulse BARREIRA[0] for 1 cycle. Required: LED[0] = 1111 0000 1111 0000 then 0; BUSY[0] high for exactly 16 cycles; other channels stay 0.
3. Continuous and clear: MODE[1] = 1, trigger channel 1. Required: LED[1] toggles every 4 cycles for 40 cycles. Then assert CLR[1] for 1 cycle. Required: LED[1] = 0 and BUSY[1] = 0 at the next edge, and they stay 0.
4. Retrigger: trigger channel 2, then give a new rising edge during its second ON phase. Required: 3 ON phases in total; BUSY[2] high for 24 cycles; phase alignment is unbroken.
5. Simultaneous events:
   - CLR[3] and a rising edge on BARREIRA[3] in the same cycle while idle: required, no blink.
   - Reset mid-burst on channel 0: required, LED[0] = 0 at the next edge.
6. Independent channels: trigger channel 0 and channel 3 two cycles apart. Required: identical 16-cycle patterns, offset by exactly 2 cycles.
